seq_det_sched: RTL and testbench
================================

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one seq_det instance.
REQ-002 SHALL have parameter WORD_W, default 8: bits serialized per job.
REQ-003 SHALL have parameter DET_LAT, default 2: cycles from det_in bit to its det_out response.
REQ-004 SHALL have parameter DRAIN_BIT, default 1'b1: value driven on det_in outside SHIFT.
REQ-005 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port req  input  N_REQ: per-requester job request, level, held until granted.
REQ-008 SHALL have port data_in  input  N_REQ*WORD_W: requester i word at bits [i*WORD_W +: WORD_W].
REQ-009 SHALL have port grant  output  N_REQ: one-hot, one-cycle pulse; word captured that cycle.
REQ-010 SHALL have port busy  output  1: high in every state except IDLE.
REQ-011 SHALL have port det_rst  output  1: drives seq_det rst.
REQ-012 SHALL have port det_in  output  1: drives seq_det serial_in.
REQ-013 SHALL have port det_out  input  1: from seq_det serial_out.
REQ-014 SHALL have port done  output  1: one-cycle pulse, job result valid.
REQ-015 SHALL have port done_id  output  clog2(N_REQ): index of requester whose job finished.
REQ-016 SHALL have port hit_cnt  output  4: det_out-high cycles counted in the job window, saturating at 15.
REQ-017 SHALL have port hit  output  1: equals |hit_cnt.

Function
REQ-018 SHALL implement FSM IDLE -> [CLR] -> SHIFT -> DRAIN -> DONE -> IDLE.
REQ-019 IDLE: when any req bit is high, SHALL grant exactly one requester, round-robin starting at last_grant+1 mod N_REQ, capture its word, and leave IDLE the next cycle.
REQ-020 With no req high, SHALL remain in IDLE with grant=0.
REQ-021 SHIFT SHALL last exactly WORD_W cycles; det_in = captured word MSB-first, one bit per cycle.
REQ-022 DRAIN SHALL last exactly DET_LAT cycles with det_in = DRAIN_BIT; DRAIN_BIT SHALL also drive det_in in IDLE, CLR and DONE.
REQ-023 Sampling window SHALL be WORD_W consecutive cycles: SHIFT cycle index DET_LAT (0-based) through the last DRAIN cycle; hit_cnt increments by 1 per window cycle with det_out=1.
REQ-024 hit_cnt SHALL clear on entry to SHIFT and saturate at 4'd15.
REQ-025 DONE SHALL last one cycle with done=1; done_id, hit_cnt and hit SHALL then hold until the next DONE.
REQ-026 Latency: grant in cycle T -> done in cycle T+WORD_W+DET_LAT+2 (macro defined) or T+WORD_W+DET_LAT+1 (macro undefined).
REQ-027 req changes after grant SHALL be ignored until the FSM returns to IDLE; a req high during DONE SHALL be granted no earlier than the next IDLE cycle.
REQ-028 Granted requester SHALL be lowest priority in the next arbitration; with a single active requester it SHALL be re-granted every job.

Reset
REQ-029 While rst=1 SHALL force IDLE: grant=0, busy=0, done=0, done_id=0, hit_cnt=0, hit=0, det_in=DRAIN_BIT, det_rst=1.
REQ-030 rst SHALL set the round-robin pointer so requester 0 has highest priority on the first arbitration.
REQ-031 rst asserted mid-job SHALL abort the job with no done pulse; the aborted requester SHALL re-request.

Configuration
REQ-032 Macro SEQ_SCHED_CLR_EN SHALL select per-job detector clear.
REQ-033 Defined: CLR state SHALL last one cycle between IDLE and SHIFT with det_rst=1; det_rst = rst OR (state==CLR).
REQ-034 Undefined: no CLR state, IDLE -> SHIFT directly; det_rst = rst; detector state carries between jobs.

Verification
REQ-035 Single job: WORD_W=8, DET_LAT=2, macro defined, req=4'b0001, word 8'b0101_1011 -> grant=4'b0001 at T, det_rst high at T+1, done at T+12, done_id=0, hit_cnt=1, hit=1.
REQ-036 No match: word 8'h00 from requester 2 -> done_id=2, hit_cnt=0, hit=0.
REQ-037 Round-robin: req=4'b1111 held, distinct words -> grant order 0,1,2,3,0; one done per grant, done_id matching.
REQ-038 Saturation: stub det_out tied to 1, WORD_W=16 -> hit_cnt=15, not wrap to 0.
REQ-039 Reset mid-job: rst pulsed at SHIFT cycle 3 -> no done, busy=0 and det_rst=1 that cycle; next req=4'b0010 granted first-priority order from requester 0 pointer.
REQ-040 Macro undefined: same stimulus as REQ-035 -> no det_rst pulse outside rst, done at T+11.

Source files
------------

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler that serializes one requester word at a
// time into a shared serial sequence detector and counts its hits per job.
// Optional per-job detector clear (CLR state): define SEQ_SCHED_CLR_EN.
module seq_det_sched #(
    parameter int N_REQ     = 4,
    parameter int WORD_W    = 8,
    parameter int DET_LAT   = 2,
    parameter bit DRAIN_BIT = 1'b1,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] data_in,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    det_rst,
    output logic                    det_in,
    input  logic                    det_out,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [3:0]              hit_cnt,
    output logic                    hit
);
    // r_cnt spans SHIFT and DRAIN as one phase: 0 .. WORD_W+DET_LAT-1
    localparam int CNT_W = $clog2(WORD_W + DET_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_done_id;
    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_acc;
    logic [3:0]        r_hit_cnt;

    logic [ID_W-1:0]   w_pick;
    logic              w_in_win;
    logic [3:0]        w_acc_nxt;

    // Round-robin pick: first requesting index at or after r_ptr (descending
    // scan so the smallest offset is assigned last and wins).
    always_comb begin
        w_pick = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % N_REQ])
                w_pick = ID_W'((int'(r_ptr) + k) % N_REQ);
        end
    end

    // Response to bit k shows up DET_LAT cycles later, so the window starts
    // at phase index DET_LAT and runs to the end of DRAIN.
    assign w_in_win  = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) &&
                       (r_cnt >= CNT_W'(DET_LAT));
    assign w_acc_nxt = (w_in_win && det_out && (r_acc != 4'd15)) ? r_acc + 4'd1 : r_acc;

    // Job FSM: arbitrate, capture word, shift, drain, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_id      <= '0;
            r_done_id <= '0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_hit_cnt <= '0;
        end else begin
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (r_grant != '0) begin
                        // grant cycle: capture word, rotate priority past winner
                        r_shreg <= data_in[r_id*WORD_W +: WORD_W];
                        r_ptr   <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
                        r_cnt   <= '0;
                        r_acc   <= '0;
`ifdef SEQ_SCHED_CLR_EN
                        r_state <= S_CLR;
`else
                        r_state <= S_SHIFT;
`endif
                    end else if (req != '0) begin
                        r_grant <= N_REQ'(1) << w_pick;
                        r_id    <= w_pick;
                    end
                end
                S_CLR: begin
                    r_state <= S_SHIFT;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                end
                S_SHIFT, S_DRAIN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= w_acc_nxt;
                    if (r_state == S_SHIFT)
                        r_shreg <= r_shreg << 1;
                    // end-of-window check first so DET_LAT=0 skips DRAIN
                    if (r_cnt == CNT_W'(WORD_W + DET_LAT - 1)) begin
                        r_state   <= S_DONE;
                        r_done_id <= r_id;
                        r_hit_cnt <= w_acc_nxt;
                    end else if (r_cnt == CNT_W'(WORD_W - 1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced to their reset values in the same cycle rst is high.
    assign grant   = rst ? '0 : r_grant;
    assign busy    = !rst && (r_state != S_IDLE);
    assign done    = !rst && (r_state == S_DONE);
    assign done_id = rst ? '0 : r_done_id;
    assign hit_cnt = rst ? '0 : r_hit_cnt;
    assign hit     = |hit_cnt;
    assign det_in  = (!rst && (r_state == S_SHIFT)) ? r_shreg[WORD_W-1] : DRAIN_BIT;
`ifdef SEQ_SCHED_CLR_EN
    assign det_rst = rst | (r_state == S_CLR);
`else
    assign det_rst = rst;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: a stub "1101" detector with DET_LAT pipeline sits on
// the serial link; a reference model predicts grants and hit counts, expected
// results go to a scoreboard queue that a done-monitor drains. A second
// instance with WORD_W=16 and det_out tied high exercises saturation.
module tb_seq_det_sched;
    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 2;
`ifdef SEQ_SCHED_CLR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int LAT = W + L + 1 + CLR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] words;
    logic [N-1:0] grant;
    logic busy, det_rst, det_in, det_out, done, hit;
    logic [1:0] done_id;
    logic [3:0] hit_cnt;

    logic [N-1:0]    sat_req = 4'b0001;
    logic [N*16-1:0] sat_data = '0;
    logic [N-1:0] sat_grant;
    logic sat_busy, sat_det_rst, sat_det_in, sat_done, sat_hit;
    logic [1:0] sat_id;
    logic [3:0] sat_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seq_det_sched #(.N_REQ(N), .WORD_W(W), .DET_LAT(L), .DRAIN_BIT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data_in(words), .grant(grant),
        .busy(busy), .det_rst(det_rst), .det_in(det_in), .det_out(det_out),
        .done(done), .done_id(done_id), .hit_cnt(hit_cnt), .hit(hit));

    seq_det_sched #(.N_REQ(N), .WORD_W(16), .DET_LAT(L), .DRAIN_BIT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .req(sat_req), .data_in(sat_data), .grant(sat_grant),
        .busy(sat_busy), .det_rst(sat_det_rst), .det_in(sat_det_in), .det_out(1'b1),
        .done(sat_done), .done_id(sat_id), .hit_cnt(sat_cnt), .hit(sat_hit));

    // Stub detector: flags overlapping "1101" (oldest bit first), L cycles late.
    logic [2:0]   st_hist;
    logic [L-1:0] st_pipe;
    always @(posedge clk) begin
        if (det_rst) begin
            st_hist <= '0;
            st_pipe <= '0;
        end else begin
            st_hist <= {st_hist[1:0], det_in};
            st_pipe <= {st_pipe[L-2:0], ({st_hist, det_in} == 4'b1101)};
        end
    end
    assign det_out = st_pipe[L-1];

    typedef struct { int id; int hits; int t; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   sat_seen = 0;
    int   m_ptr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // First requester at or after the rotating pointer.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Detector history before the word: cleared with per-job clear, otherwise
    // the drain/idle ones that always precede a job.
    function automatic int exp_hits(input logic [W-1:0] wd);
        logic [W+2:0] s;
        int n;
        n = 0;
        s = {((CLR != 0) ? 3'b000 : 3'b111), wd};
        for (int k = 0; k < W; k++)
            if (s[W+2-k -: 4] == 4'b1101) n++;
        return (n > 15) ? 15 : n;
    endfunction

    // One job: wait grant, check it, queue the expectation, load the next req,
    // then follow the serial stream through SHIFT and DRAIN.
    task automatic run_job(input logic [N-1:0] nreq, input bit rnd_words);
        int id, t;
        bit got;
        logic [W-1:0] wd;
        got = 0;
        id = rr_pick(req, m_ptr);
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        chk("grant_wait", 32'(got), 1);
        if (!got) return;
        chk("grant", 32'(grant), 32'(1) << id);
        wd = words[id];
        t  = cyc;
        sbq.push_back('{id, exp_hits(wd), t});
        m_ptr = (id + 1) % N;
        @(posedge clk); #1;
        req = nreq;
        if (rnd_words)
            for (int i = 0; i < N; i++) words[i] = W'($urandom);
        @(negedge clk);
        chk("det_rst_job", 32'(det_rst), CLR);
        chk("busy_job", 32'(busy), 1);
        if (CLR != 0) @(negedge clk);
        for (int k = 0; k < W + L; k++) begin
            chk("det_in", 32'(det_in), (k < W) ? 32'(wd[W-1-k]) : 32'(1));
            chk("no_regrant", 32'(grant), 0);
            if (k < W + L - 1) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Done monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_id", 32'(done_id), 32'(mon_e.id));
                chk("hit_cnt", 32'(hit_cnt), 32'(mon_e.hits));
                chk("hit", 32'(hit), 32'(mon_e.hits != 0));
                chk("latency", 32'(cyc), 32'(mon_e.t + LAT));
            end
        end
        if (sat_done) begin
            chk("sat_hit_cnt", 32'(sat_cnt), 15);
            chk("sat_hit", 32'(sat_hit), 1);
            chk("sat_id", 32'(sat_id), 0);
            sat_seen++;
        end
    end

    initial begin
        logic [N-1:0] nr;
        req   = '0;
        words = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_det_in", 32'(det_in), 1);
        chk("rst_det_rst", 32'(det_rst), 1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_grant", 32'(grant), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Directed: 0x5B from requester 0, then 0x00 from requester 2
        words[0] = 8'h5B; words[1] = 8'hFF; words[2] = 8'h00; words[3] = 8'hFF;
        @(posedge clk); #1 req = 4'b0001;
        run_job(4'b0100, 1'b0);
        run_job(4'b0000, 1'b0);
        repeat (20) @(negedge clk);

        // Round robin from a fresh pointer with all requesters held
        do_reset();
        words = {8'h3C, 8'hDA, 8'h6D, 8'hB6};
        req = 4'b1111;
        repeat (4) run_job(4'b1111, 1'b0);
        run_job(4'b0000, 1'b0);
        repeat (20) @(negedge clk);

        // Reset in SHIFT cycle 3: job aborted, pointer back to requester 0
        @(posedge clk); #1 req = 4'b0001;
        begin
            bit got;
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (grant != '0) got = 1;
            end
            chk("abort_grant", 32'(grant), 1);
        end
        @(posedge clk); #1 req = '0;
        repeat (3 + CLR) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_det_rst", 32'(det_rst), 1);
        chk("abort_done", 32'(done), 0);
        chk("abort_hit_cnt", 32'(hit_cnt), 0);
        @(posedge clk); #1 rst = 1'b0;
        m_ptr = 0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end
        @(posedge clk); #1 req = 4'b0011;
        run_job(4'b0000, 1'b0);
        repeat (20) @(negedge clk);

        // Randomized jobs with req/words reshuffled while the FSM is busy
        @(posedge clk); #1;
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) words[i] = W'($urandom);
        for (int j = 0; j < 30; j++) begin
            nr = (j == 29) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_job(nr, 1'b1);
        end

        for (int c = 0; c < 40 && sbq.size() != 0; c++) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 0);
        chk("sat_seen", 32'(sat_seen > 0), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
